ex_muldiv_unit: RTL and testbench

Multi-cycle RV32M execute unit that sits in the EX stage beside the single-cycle ALU.
- Accepts one M-extension operation at a time from the ID/EX register over a valid/ready handshake.
- Computes the operation with a pipelined multiplier or an iterative restoring divider.
- Holds the result until the EX/MEM side accepts it.
- Generalises the EX datapath to configurable width, multiplier depth and divider throughput, and adds stall/flush behaviour.

---
 rtl/ex_muldiv_unit.sv | 159 +++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// RV32M execute unit: pipelined multiplier plus iterative restoring divider, one op at a time.
// Result held in DONE until accepted; flush or reset aborts any in-flight operation.
module ex_muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2,
  parameter int DIV_BITS   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [4:0]       rd_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [4:0]       rd_o,
  output logic             busy_o
);
  localparam int DIV_CYCLES = WIDTH / DIV_BITS;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
  state_t state;

  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, d_q, q_q, result_q;
  logic [WIDTH:0]     r_q;
  logic               neg_q, neg_r, out_valid_q;
  logic [4:0]         rd_q;
  logic [15:0]        cnt;
  logic [2*WIDTH-1:0] pipe [MUL_STAGES];

  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic               a_neg, b_neg, accept;
  logic [WIDTH-1:0]   a_abs, b_abs, q_nx;
  logic [WIDTH:0]     r_nx;

  assign accept      = in_valid_i && (state == IDLE) && !flush_i;
  assign in_ready_o  = (state == IDLE);
  assign busy_o      = (state != IDLE);
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign rd_o        = rd_q;

  // Product formed from the live operands so the first pipe register captures it on the accept edge.
  always_comb begin
    a_ext = {{WIDTH{((op_i == 3'd1) || (op_i == 3'd2)) && a_i[WIDTH-1]}}, a_i};
    b_ext = {{WIDTH{(op_i == 3'd1) && b_i[WIDTH-1]}}, b_i};
    prod  = a_ext * b_ext;
  end

  assign a_neg = !op_i[0] && a_i[WIDTH-1];
  assign b_neg = !op_i[0] && b_i[WIDTH-1];
  assign a_abs = a_neg ? -a_i : a_i;
  assign b_abs = b_neg ? -b_i : b_i;

  always_comb begin
    r_nx = r_q;
    q_nx = q_q;
    for (int i = 0; i < DIV_BITS; i++) begin
      r_nx = {r_nx[WIDTH-1:0], q_nx[WIDTH-1]};
      q_nx = {q_nx[WIDTH-2:0], 1'b0};
      if (r_nx >= {1'b0, d_q}) begin
        r_nx    = r_nx - {1'b0, d_q};
        q_nx[0] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MUL_STAGES; i++) pipe[i] <= '0;
    end else begin
      if (accept) pipe[0] <= prod;
      for (int i = 1; i < MUL_STAGES; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      d_q         <= '0;
      q_q         <= '0;
      r_q         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      rd_q        <= '0;
      cnt         <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else if (flush_i) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid_i) begin
          op_q  <= op_i;
          a_q   <= a_i;
          b_q   <= b_i;
          rd_q  <= rd_i;
          d_q   <= b_abs;
          q_q   <= a_abs;
          r_q   <= '0;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          cnt   <= '0;
          state <= op_i[2] ? DIV : MUL;
        end
        MUL: if (cnt == 16'(MUL_STAGES - 1)) begin
          result_q    <= (op_q == 3'd0) ? pipe[MUL_STAGES-1][WIDTH-1:0]
                                        : pipe[MUL_STAGES-1][2*WIDTH-1:WIDTH];
          out_valid_q <= 1'b1;
          cnt         <= '0;
          state       <= DONE;
        end else begin
          cnt <= cnt + 16'd1;
        end
        DIV: if (cnt == '0 && b_q == '0) begin
          result_q    <= op_q[1] ? a_q : '1;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end else if (cnt == '0 && !op_q[0] && a_q == MIN_VAL && b_q == '1) begin
          result_q    <= op_q[1] ? '0 : a_q;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end else begin
          r_q <= r_nx;
          q_q <= q_nx;
          if (cnt == 16'(DIV_CYCLES - 1)) begin
            cnt   <= '0;
            state <= FIX;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        // Magnitudes were divided; restore signs (quotient by sign mismatch, remainder follows a).
        FIX: begin
          result_q    <= op_q[1] ? (neg_r ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0])
                                 : (neg_q ? -q_q : q_q);
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: if (out_ready_i) begin
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench: directed M-extension vectors on a DIV_BITS=1 unit and a DIV_BITS=4 unit.
module tb_ex_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_valid4 = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic [2:0]  op = '0;
  logic [31:0] a = '0, b = '0;
  logic [4:0]  rd = '0;
  logic        in_ready, out_valid, busy, rdy4, ov4, busy4;
  logic [31:0] result, res4;
  logic [4:0]  rd_o, rd4;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.WIDTH(32), .MUL_STAGES(2), .DIV_BITS(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready), .op_i(op),
    .a_i(a), .b_i(b), .rd_i(rd), .flush_i(flush), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .result_o(result), .rd_o(rd_o), .busy_o(busy));

  ex_muldiv_unit #(.WIDTH(32), .MUL_STAGES(2), .DIV_BITS(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid4), .in_ready_o(rdy4), .op_i(op),
    .a_i(a), .b_i(b), .rd_i(rd), .flush_i(flush), .out_valid_o(ov4),
    .out_ready_i(1'b1), .result_o(res4), .rd_o(rd4), .busy_o(busy4));

  typedef struct {logic [31:0] res; logic [4:0] rd; int acc; int lat;} exp_t;
  exp_t sb[$];
  exp_t sb4[$];
  int checks = 0, errors = 0, cyc = 0;
  logic pv = 1'b0, pv4 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: compares whatever the DUTs present against the head of their queues.
  always @(negedge clk) begin
    if (rst) begin
      pv  = 1'b0;
      pv4 = 1'b0;
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
        else begin
          if (!pv) chk("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
          chk("result", result, sb[0].res);
          chk("rd", {27'd0, rd_o}, {27'd0, sb[0].rd});
          if (out_ready) sb.delete(0);
        end
      end
      pv = out_valid;
      if (ov4) begin
        if (sb4.size() == 0) chk("unexpected_valid4", 32'd1, 32'd0);
        else begin
          if (!pv4) chk("latency4", 32'(cyc - sb4[0].acc), 32'(sb4[0].lat));
          chk("result4", res4, sb4[0].res);
          chk("rd4", {27'd0, rd4}, {27'd0, sb4[0].rd});
          sb4.delete(0);
        end
      end
      pv4 = ov4;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] r, input logic [31:0] res, input int lat,
                       input bit push, input bit to4);
    int t = 0;
    op = o; a = x; b = y; rd = r;
    if (to4) in_valid4 = 1'b1; else in_valid = 1'b1;
    while (!(to4 ? rdy4 : in_ready) && t < 200) begin
      step();
      t++;
    end
    if (t >= 200) chk("accept_timeout", 32'd0, 32'd1);
    step();
    in_valid = 1'b0; in_valid4 = 1'b0;
    a = $urandom; b = $urandom; rd = 5'($urandom);
    if (push) begin
      if (to4) sb4.push_back('{res, r, cyc, lat});
      else     sb.push_back('{res, r, cyc, lat});
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || sb4.size() != 0) && t < 200) begin
      step();
      t++;
    end
    if (t >= 200) begin
      chk("drain_timeout", 32'd0, 32'd1);
      sb.delete();
      sb4.delete();
    end
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!out_valid && t < 100) begin
      step();
      t++;
    end
    if (t >= 100) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    step(); step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd", {27'd0, rd_o}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    step();

    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd5,  32'h4000_0000, 2, 1, 0);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF, 2, 1, 0);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 2, 1, 0);
    issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'h0000_0001, 2, 1, 0);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFD, 33, 1, 0);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFF, 33, 1, 0);
    issue(3'd5, 32'd7,         32'd0,         5'd12, 32'hFFFF_FFFF, 1, 1, 0);
    issue(3'd7, 32'd7,         32'd0,         5'd13, 32'd7,         1, 1, 0);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1, 1, 0);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0,         1, 1, 0);
    issue(3'd5, 32'd100,       32'd7,         5'd16, 32'd14,        33, 1, 0);
    issue(3'd7, 32'd100,       32'd7,         5'd17, 32'd2,         33, 1, 0);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd18, 32'hFFFF_FFFD, 9, 1, 1);
    drain();

    // Backpressure: result held while downstream stalls
    out_ready = 1'b0;
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd19, 32'hFFFF_FFFE, 2, 1, 0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_idle_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_idle_valid", {31'd0, out_valid}, 32'd0);

    // Flush partway through a divide
    issue(3'd4, 32'd1000, 32'd3, 5'd20, 32'd0, 0, 0, 0);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_div_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_div_valid", {31'd0, out_valid}, 32'd0);
    repeat (40) step();

    // Flush while a result waits in DONE
    out_ready = 1'b0;
    issue(3'd0, 32'd2, 32'd3, 5'd21, 32'd6, 2, 1, 0);
    wait_valid();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    if (sb.size() != 0) sb.delete(0);
    chk("flush_done_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_done_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    step();

    // Flush coincident with an offer in IDLE blocks the accept
    op = 3'd0; a = 32'd9; b = 32'd9; in_valid = 1'b1; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_blocks_accept", {31'd0, busy}, 32'd0);
    repeat (4) step();

    // Reset in the middle of a multiply
    issue(3'd0, 32'd5, 32'd5, 5'd22, 32'd0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_mid_result", result, 32'd0);
    step();
    rst = 1'b0;
    step();
    issue(3'd0, 32'd3, 32'd4, 5'd9, 32'd12, 2, 1, 0);
    drain();
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
